alu_op_sequencer: RTL

- Issue-side controller for the 8-bit ripple ALU datapath. It accepts operation requests over a valid/ready handshake, drives the ALU operand and select inputs from registers, and waits a programmable settle time.
- It then captures sum/carry and returns the result over a valid/ready response channel.
- It extends the 8-bit ALU to 16-bit add by sequencing a low-byte pass, a high-byte pass and, when needed, a carry-fixup pass. This is required because the ALU has no carry-in.

---
 rtl/alu_op_sequencer.sv | 189 ++++++++++++++++++
 1 files changed

// File: rtl/alu_op_sequencer.sv
// Issue-side sequencer for the 8-bit carry-less ALU: one operation in flight.
// 16-bit adds run as a low pass, a high pass and, if the low byte carried, a +1 fixup pass.
module alu_op_sequencer #(
    parameter int SETTLE  = 2,
    parameter int COUNT_W = 8
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               req_valid,
    output logic               req_ready,
    input  logic [15:0]        req_x,
    input  logic [15:0]        req_y,
    input  logic [3:0]         req_sel,
    input  logic               req_wide,
    output logic [7:0]         alu_x,
    output logic [7:0]         alu_y,
    output logic [3:0]         alu_sel,
    input  logic [7:0]         alu_sum,
    input  logic               alu_carry,
    output logic               rsp_valid,
    input  logic               rsp_ready,
    output logic [15:0]        rsp_result,
    output logic               rsp_carry,
    output logic               busy,
    output logic [COUNT_W-1:0] op_count
);

    localparam int CNT_W = (SETTLE > 1) ? $clog2(SETTLE) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(SETTLE - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOW,
        S_HIGH,
        S_FIX,
        S_RESP
    } state_t;

    state_t              state_reg,      state_next;
    logic [CNT_W-1:0]    cnt_reg,        cnt_next;
    logic [7:0]          x_hi_reg,       x_hi_next;
    logic [7:0]          y_hi_reg,       y_hi_next;
    logic                wide_reg,       wide_next;
    logic [7:0]          lo_reg,         lo_next;
    logic                c_lo_reg,       c_lo_next;
    logic                c_hi_reg,       c_hi_next;
    logic [7:0]          alu_x_reg,      alu_x_next;
    logic [7:0]          alu_y_reg,      alu_y_next;
    logic [3:0]          alu_sel_reg,    alu_sel_next;
    logic [15:0]         rsp_result_reg, rsp_result_next;
    logic                rsp_carry_reg,  rsp_carry_next;
    logic [COUNT_W-1:0]  op_count_reg,   op_count_next;

    logic pass_done;
    assign pass_done = (cnt_reg == CNT_LAST);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg      <= S_IDLE;
            cnt_reg        <= '0;
            x_hi_reg       <= '0;
            y_hi_reg       <= '0;
            wide_reg       <= 1'b0;
            lo_reg         <= '0;
            c_lo_reg       <= 1'b0;
            c_hi_reg       <= 1'b0;
            alu_x_reg      <= '0;
            alu_y_reg      <= '0;
            alu_sel_reg    <= '0;
            rsp_result_reg <= '0;
            rsp_carry_reg  <= 1'b0;
            op_count_reg   <= '0;
        end else begin
            state_reg      <= state_next;
            cnt_reg        <= cnt_next;
            x_hi_reg       <= x_hi_next;
            y_hi_reg       <= y_hi_next;
            wide_reg       <= wide_next;
            lo_reg         <= lo_next;
            c_lo_reg       <= c_lo_next;
            c_hi_reg       <= c_hi_next;
            alu_x_reg      <= alu_x_next;
            alu_y_reg      <= alu_y_next;
            alu_sel_reg    <= alu_sel_next;
            rsp_result_reg <= rsp_result_next;
            rsp_carry_reg  <= rsp_carry_next;
            op_count_reg   <= op_count_next;
        end
    end

    always_comb begin
        state_next      = state_reg;
        cnt_next        = cnt_reg;
        x_hi_next       = x_hi_reg;
        y_hi_next       = y_hi_reg;
        wide_next       = wide_reg;
        lo_next         = lo_reg;
        c_lo_next       = c_lo_reg;
        c_hi_next       = c_hi_reg;
        alu_x_next      = alu_x_reg;
        alu_y_next      = alu_y_reg;
        alu_sel_next    = alu_sel_reg;
        rsp_result_next = rsp_result_reg;
        rsp_carry_next  = rsp_carry_reg;
        op_count_next   = op_count_reg;

        case (state_reg)
            S_IDLE: begin
                if (req_valid) begin
                    x_hi_next    = req_x[15:8];
                    y_hi_next    = req_y[15:8];
                    // Only a plain add can be chained; other functions stay 8-bit.
                    wide_next    = req_wide && (req_sel == 4'h0);
                    alu_x_next   = req_x[7:0];
                    alu_y_next   = req_y[7:0];
                    alu_sel_next = req_sel;
                    cnt_next     = '0;
                    state_next   = S_LOW;
                end
            end
            S_LOW: begin
                if (pass_done) begin
                    cnt_next = '0;
                    if (wide_reg) begin
                        lo_next      = alu_sum;
                        c_lo_next    = alu_carry;
                        alu_x_next   = x_hi_reg;
                        alu_y_next   = y_hi_reg;
                        alu_sel_next = 4'h0;
                        state_next   = S_HIGH;
                    end else begin
                        rsp_result_next = {8'h00, alu_sum};
                        rsp_carry_next  = alu_carry;
                        state_next      = S_RESP;
                    end
                end else begin
                    cnt_next = cnt_reg + CNT_W'(1);
                end
            end
            S_HIGH: begin
                if (pass_done) begin
                    cnt_next = '0;
                    if (!c_lo_reg) begin
                        rsp_result_next = {alu_sum, lo_reg};
                        rsp_carry_next  = alu_carry;
                        state_next      = S_RESP;
                    end else begin
                        // No carry-in on the ALU, so add the low carry as a separate +1 pass.
                        c_hi_next    = alu_carry;
                        alu_x_next   = alu_sum;
                        alu_y_next   = 8'h01;
                        alu_sel_next = 4'h0;
                        state_next   = S_FIX;
                    end
                end else begin
                    cnt_next = cnt_reg + CNT_W'(1);
                end
            end
            S_FIX: begin
                if (pass_done) begin
                    cnt_next        = '0;
                    rsp_result_next = {alu_sum, lo_reg};
                    rsp_carry_next  = c_hi_reg | alu_carry;
                    state_next      = S_RESP;
                end else begin
                    cnt_next = cnt_reg + CNT_W'(1);
                end
            end
            S_RESP: begin
                if (rsp_ready) begin
                    op_count_next = op_count_reg + COUNT_W'(1);
                    state_next    = S_IDLE;
                end
            end
            default: state_next = S_IDLE;
        endcase
    end

    assign req_ready  = (state_reg == S_IDLE);
    assign busy       = (state_reg != S_IDLE);
    assign rsp_valid  = (state_reg == S_RESP);
    assign alu_x      = alu_x_reg;
    assign alu_y      = alu_y_reg;
    assign alu_sel    = alu_sel_reg;
    assign rsp_result = rsp_result_reg;
    assign rsp_carry  = rsp_carry_reg;
    assign op_count   = op_count_reg;

endmodule
